// File: rtl/mem_port_arbiter_if.sv
// Shared-memory-port bundle: fetch requester, load/store requester and the memory side.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 64
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_ack;
   logic [31:0]       f_rdata;
   logic              d_req;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [63:0]       d_wdata;
   logic              d_ack;
   logic [63:0]       d_rdata;
   logic              mem_en;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [63:0]       mem_rdata;
   logic              busy;

   // Arbiter side.
   modport slave (
      input  f_req, f_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
      output f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_write, mem_addr, mem_wdata, busy
   );

   // Requester / memory model side.
   modport master (
      output f_req, f_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
      input  f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_write, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// one fixed-latency access at a time with a one-cycle ack and registered read data.
//
// state    | meaning
// S_IDLE   | no access; sample requests, grant on the next edge
// S_ACCESS | mem_en high, counter runs MEM_LAT-1 .. 0, loads captured on exit
// S_DONE   | owner's ack pulses for this single cycle
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = 64
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   localparam logic OWN_FETCH = 1'b0;
   localparam logic OWN_DATA  = 1'b1;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [31:0]       f_rdata_q, f_rdata_d;
   logic [63:0]       d_rdata_q, d_rdata_d;
   logic              grant_data;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      last_d     = last_q;
      write_d    = write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      f_rdata_d  = f_rdata_q;
      d_rdata_d  = d_rdata_q;
      grant_data = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.f_req || bus.d_req) begin
               // On contention the side that did not win last time gets the port.
               grant_data = bus.d_req && (!bus.f_req || (last_q == OWN_FETCH));
               owner_d    = grant_data ? OWN_DATA : OWN_FETCH;
               last_d     = grant_data ? OWN_DATA : OWN_FETCH;
               addr_d     = grant_data ? bus.d_addr : bus.f_addr;
               write_d    = grant_data && bus.d_write;
               wdata_d    = grant_data ? bus.d_wdata : 64'd0;
               cnt_d      = CNT_LOAD;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               if (!write_q) begin
                  if (owner_q == OWN_DATA)
                     d_rdata_d = bus.mem_rdata;
                  else
                     f_rdata_d = addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         owner_q   <= OWN_FETCH;
         last_q    <= OWN_DATA;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 64'd0;
         f_rdata_q <= 32'd0;
         d_rdata_q <= 64'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         f_rdata_q <= f_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Strobes decode straight from the state register so reset removes them without waiting for an edge.
   assign bus.mem_en    = (state_q == S_ACCESS);
   assign bus.mem_write = (state_q == S_ACCESS) && write_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.f_ack     = (state_q == S_DONE) && (owner_q == OWN_FETCH);
   assign bus.d_ack     = (state_q == S_DONE) && (owner_q == OWN_DATA);
   assign bus.f_rdata   = f_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: expected acks/read data queued at stimulus, checked at ack.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_W(64)) bus2 ();
   mem_port_arbiter_if #(.ADDR_W(64)) bus1 ();

   mem_port_arbiter #(.MEM_LAT(2), .ADDR_W(64)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));
   mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(64)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

   typedef struct {
      logic        is_data;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   logic [63:0] cvals [0:4] = '{64'h0101_0101_1010_1010, 64'h0202_0202_2020_2020,
                                64'h0303_0303_3030_3030, 64'h0404_0404_4040_4040,
                                64'h0505_0505_5050_5050};

   task automatic init_inputs();
      bus2.f_req = 0; bus2.f_addr = '0; bus2.d_req = 0; bus2.d_write = 0;
      bus2.d_addr = '0; bus2.d_wdata = '0; bus2.mem_rdata = '0;
      bus1.f_req = 0; bus1.f_addr = '0; bus1.d_req = 0; bus1.d_write = 0;
      bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      init_inputs();
      repeat (2) @(negedge clock);
      checks++;
      if ({bus2.mem_en, bus2.mem_write, bus2.f_ack, bus2.d_ack, bus2.busy} !== 5'b0) begin
         errors++; $display("FAIL reset_strobes: got %b expected 00000",
            {bus2.mem_en, bus2.mem_write, bus2.f_ack, bus2.d_ack, bus2.busy});
      end
      checks++;
      if (bus2.mem_addr !== 64'd0 || bus2.mem_wdata !== 64'd0) begin
         errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", bus2.mem_addr, bus2.mem_wdata);
      end
      checks++;
      if (bus2.f_rdata !== 32'd0 || bus2.d_rdata !== 64'd0) begin
         errors++; $display("FAIL reset_rdata: got f=%h d=%h expected 0", bus2.f_rdata, bus2.d_rdata);
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({bus2.busy, bus2.mem_en, bus1.busy, bus1.mem_en} !== 4'b0) begin
         errors++; $display("FAIL idle_after_reset: got %b expected 0000",
            {bus2.busy, bus2.mem_en, bus1.busy, bus1.mem_en});
      end
   endtask

   task automatic test_single_fetch();
      exp_t e;
      int   en_cnt, first_en;
      logic got;
      @(negedge clock);
      bus2.f_addr = 64'h1004; bus2.mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD; bus2.f_req = 1'b1;
      e.is_data = 1'b0; e.data = 64'h0000_0000_AAAA_BBBB; sb.push_back(e);
      en_cnt = 0; first_en = -1; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clock);
         if (bus2.mem_en) begin
            en_cnt++;
            if (first_en < 0) first_en = k;
            checks++;
            if (bus2.mem_addr !== 64'h1004 || bus2.mem_write !== 1'b0) begin
               errors++; $display("FAIL fetch_mem_bus: got addr=%h wr=%b expected 1004/0", bus2.mem_addr, bus2.mem_write);
            end
         end
         if (bus2.f_ack || bus2.d_ack) begin
            got = 1'b1; bus2.f_req = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({bus2.f_ack, bus2.d_ack} !== {~e.is_data, e.is_data}) begin
               errors++; $display("FAIL fetch_ack_owner: got f=%b d=%b expected f=1 d=0", bus2.f_ack, bus2.d_ack);
            end
            checks++;
            if ({32'd0, bus2.f_rdata} !== e.data) begin
               errors++; $display("FAIL fetch_rdata: got %h expected %h", bus2.f_rdata, e.data[31:0]);
            end
            checks++;
            if (en_cnt != 2 || k - first_en != 2) begin
               errors++; $display("FAIL fetch_timing: got en_cycles=%0d ack_offset=%0d expected 2/2", en_cnt, k - first_en);
            end
         end
      end
      if (!got) begin
         checks++; errors++; $display("FAIL fetch_timeout: got no ack expected f_ack");
      end
      @(negedge clock);
      checks++;
      if ({bus2.f_ack, bus2.busy} !== 2'b00) begin
         errors++; $display("FAIL fetch_ack_pulse: got ack=%b busy=%b expected 0/0", bus2.f_ack, bus2.busy);
      end
   endtask

   task automatic test_store();
      exp_t e;
      int   en_cnt;
      logic got;
      @(negedge clock);
      bus2.d_addr = 64'h2000; bus2.d_wdata = 64'h0123_4567_89AB_CDEF; bus2.d_write = 1'b1;
      bus2.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF; bus2.d_req = 1'b1;
      e.is_data = 1'b1; e.data = 64'd0; sb.push_back(e);
      en_cnt = 0; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clock);
         if (bus2.mem_en) begin
            en_cnt++;
            checks++;
            if (bus2.mem_write !== 1'b1 || bus2.mem_addr !== 64'h2000 || bus2.mem_wdata !== 64'h0123_4567_89AB_CDEF) begin
               errors++; $display("FAIL store_mem_bus: got wr=%b addr=%h wdata=%h expected 1/2000/0123456789abcdef",
                  bus2.mem_write, bus2.mem_addr, bus2.mem_wdata);
            end
         end
         if (bus2.f_ack || bus2.d_ack) begin
            got = 1'b1; bus2.d_req = 1'b0; bus2.d_write = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({bus2.f_ack, bus2.d_ack} !== {~e.is_data, e.is_data}) begin
               errors++; $display("FAIL store_ack_owner: got f=%b d=%b expected f=0 d=1", bus2.f_ack, bus2.d_ack);
            end
            checks++;
            if (bus2.d_rdata !== e.data) begin
               errors++; $display("FAIL store_rdata_kept: got %h expected %h", bus2.d_rdata, e.data);
            end
            checks++;
            if (en_cnt != 2) begin
               errors++; $display("FAIL store_en_cycles: got %0d expected 2", en_cnt);
            end
         end
      end
      if (!got) begin
         checks++; errors++; $display("FAIL store_timeout: got no ack expected d_ack");
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic test_contention();
      exp_t e;
      int   n_ack, last_k;
      reset = 1'b1;
      bus2.f_addr = 64'h104; bus2.d_addr = 64'h40; bus2.d_write = 1'b0;
      bus2.mem_rdata = cvals[0]; bus2.f_req = 1'b1; bus2.d_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e.is_data = (i % 2) == 1;
         e.data    = e.is_data ? cvals[i] : {32'd0, cvals[i][63:32]};
         sb.push_back(e);
      end
      @(negedge clock);
      reset = 1'b0;
      n_ack = 0; last_k = 0;
      for (int k = 0; k < 60 && n_ack < 4; k++) begin
         @(negedge clock);
         if (bus2.f_ack || bus2.d_ack) begin
            e = sb.pop_front();
            checks++;
            if ({bus2.f_ack, bus2.d_ack} !== {~e.is_data, e.is_data}) begin
               errors++; $display("FAIL contention_order[%0d]: got f=%b d=%b expected d=%b", n_ack, bus2.f_ack, bus2.d_ack, e.is_data);
            end
            checks++;
            if ((e.is_data ? bus2.d_rdata : {32'd0, bus2.f_rdata}) !== e.data) begin
               errors++; $display("FAIL contention_rdata[%0d]: got f=%h d=%h expected %h", n_ack, bus2.f_rdata, bus2.d_rdata, e.data);
            end
            if (n_ack > 0) begin
               checks++;
               if (k - last_k != 4) begin
                  errors++; $display("FAIL contention_spacing[%0d]: got %0d expected 4", n_ack, k - last_k);
               end
            end
            last_k = k;
            n_ack++;
            bus2.mem_rdata = cvals[n_ack];
            if (n_ack == 4) begin bus2.f_req = 1'b0; bus2.d_req = 1'b0; end
         end
      end
      if (n_ack < 4) begin
         checks++; errors++; $display("FAIL contention_timeout: got %0d acks expected 4", n_ack);
         bus2.f_req = 1'b0; bus2.d_req = 1'b0;
      end
      sb.delete();
      repeat (3) @(negedge clock);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   n_ack, n_en;
      int   en_at [0:1];
      logic prev_en;
      @(negedge clock);
      bus1.d_addr = 64'h10; bus1.d_write = 1'b0; bus1.mem_rdata = 64'h11; bus1.d_req = 1'b1;
      e.is_data = 1'b1; e.data = 64'h11; sb.push_back(e);
      e.data = 64'h22; sb.push_back(e);
      n_ack = 0; n_en = 0; prev_en = 1'b0; en_at[0] = 0; en_at[1] = 0;
      for (int k = 0; k < 30 && n_ack < 2; k++) begin
         @(negedge clock);
         if (bus1.mem_en && !prev_en && n_en < 2) begin
            en_at[n_en] = k;
            checks++;
            if (bus1.mem_addr !== (n_en == 0 ? 64'h10 : 64'h18)) begin
               errors++; $display("FAIL b2b_mem_addr[%0d]: got %h expected %h", n_en, bus1.mem_addr, n_en == 0 ? 64'h10 : 64'h18);
            end
            n_en++;
         end
         prev_en = bus1.mem_en;
         if (bus1.f_ack || bus1.d_ack) begin
            e = sb.pop_front();
            checks++;
            if (bus1.d_ack !== 1'b1 || bus1.f_ack !== 1'b0 || bus1.d_rdata !== e.data) begin
               errors++; $display("FAIL b2b_load[%0d]: got d_ack=%b f_ack=%b rdata=%h expected 1/0/%h",
                  n_ack, bus1.d_ack, bus1.f_ack, bus1.d_rdata, e.data);
            end
            if (n_ack == 0) begin
               bus1.d_addr = 64'h18; bus1.mem_rdata = 64'h22;
            end else begin
               bus1.d_req = 1'b0;
            end
            n_ack++;
         end
      end
      if (n_ack < 2) begin
         checks++; errors++; $display("FAIL b2b_timeout: got %0d acks expected 2", n_ack);
         bus1.d_req = 1'b0;
      end
      checks++;
      if (n_en != 2 || en_at[1] - en_at[0] != 3) begin
         errors++; $display("FAIL b2b_grant_spacing: got grants=%0d spacing=%0d expected 2/3", n_en, en_at[1] - en_at[0]);
      end
      sb.delete();
      repeat (2) @(negedge clock);
   endtask

   task automatic test_reset_mid_access();
      exp_t e;
      int   n_ack;
      logic seen;
      @(negedge clock);
      bus2.f_addr = 64'h1000; bus2.d_addr = 64'h48; bus2.d_write = 1'b0;
      bus2.mem_rdata = 64'h5555_6666_7777_8888; bus2.f_req = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clock);
         seen = bus2.mem_en;
      end
      @(negedge clock);
      checks++;
      if (!seen || bus2.mem_en !== 1'b1) begin
         errors++; $display("FAIL abort_setup: got mem_en=%b expected 1 in second access cycle", bus2.mem_en);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({bus2.mem_en, bus2.mem_write, bus2.busy, bus2.f_ack, bus2.d_ack} !== 5'b0) begin
         errors++; $display("FAIL abort_immediate: got %b expected 00000",
            {bus2.mem_en, bus2.mem_write, bus2.busy, bus2.f_ack, bus2.d_ack});
      end
      bus2.d_req = 1'b1;
      @(negedge clock);
      checks++;
      if ({bus2.f_ack, bus2.d_ack} !== 2'b00 || bus2.f_rdata !== 32'd0) begin
         errors++; $display("FAIL abort_no_ack: got f=%b d=%b f_rdata=%h expected 0/0/0", bus2.f_ack, bus2.d_ack, bus2.f_rdata);
      end
      reset = 1'b0;
      e.is_data = 1'b0; e.data = 64'h0000_0000_7777_8888; sb.push_back(e);
      e.is_data = 1'b1; e.data = 64'h5555_6666_7777_8888; sb.push_back(e);
      n_ack = 0;
      for (int k = 0; k < 30 && n_ack < 2; k++) begin
         @(negedge clock);
         if (bus2.f_ack || bus2.d_ack) begin
            e = sb.pop_front();
            checks++;
            if ({bus2.f_ack, bus2.d_ack} !== {~e.is_data, e.is_data}) begin
               errors++; $display("FAIL post_abort_order[%0d]: got f=%b d=%b expected d=%b", n_ack, bus2.f_ack, bus2.d_ack, e.is_data);
            end
            checks++;
            if ((e.is_data ? bus2.d_rdata : {32'd0, bus2.f_rdata}) !== e.data) begin
               errors++; $display("FAIL post_abort_rdata[%0d]: got f=%h d=%h expected %h", n_ack, bus2.f_rdata, bus2.d_rdata, e.data);
            end
            if (bus2.f_ack) bus2.f_req = 1'b0;
            if (bus2.d_ack) bus2.d_req = 1'b0;
            n_ack++;
         end
      end
      if (n_ack < 2) begin
         checks++; errors++; $display("FAIL post_abort_timeout: got %0d acks expected 2", n_ack);
         bus2.f_req = 1'b0; bus2.d_req = 1'b0;
      end
      sb.delete();
      repeat (2) @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_fetch();
      test_store();
      test_contention();
      test_back_to_back();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences the single shared memory port of the multicycle CPU between two requesters: the instruction-fetch path and the load/store data path driven by the control unit's controlword. It latches one request at a time and drives the memory for a fixed MEM_LAT-cycle access. It then returns a one-cycle acknowledge with registered read data. Round-robin arbitration prevents either side from starving the other.

Parameters:
MEM_LAT, 2, memory access latency in cycles, legal range 1..15.
ADDR_W, 64, address width.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high.
f_req  input  1  fetch request, held until f_ack.
f_addr  input  ADDR_W  fetch byte address.
f_ack  output  1  fetch complete, one-cycle pulse.
f_rdata  output  32  fetched instruction.
d_req  input  1  data request, held until d_ack.
d_write  input  1  1 = store, 0 = load.
d_addr  input  ADDR_W  data byte address.
d_wdata  input  64  store data.
d_ack  output  1  data access complete, one-cycle pulse.
d_rdata  output  64  load data.
mem_en  output  1  memory access enable.
mem_write  output  1  memory write strobe.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  64  memory write data.
mem_rdata  input  64  memory read data, valid at the end of the MEM_LAT-th enabled cycle.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset is asynchronous; the `reset` port is async, active-high, and `clock` is the clock. On reset:
  - state = IDLE, counter = 0, last_grant = DATA.
  - Latched addr, wdata and write = 0; f_rdata = 0, d_rdata = 0.
  - All outputs are 0. mem_en and mem_write drop immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, at a rising edge:
  - If only one req is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - If none is high, stay in IDLE.
  - On a grant: latch owner, address (f_addr or d_addr), write (d_write for data, 0 for fetch) and wdata (d_wdata, or 0 for fetch). Set last_grant = owner, counter = MEM_LAT-1, go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_write = latched write. mem_addr and mem_wdata come from the latched registers.
  - At each edge: if counter == 0, go to DONE; otherwise decrement counter.
  - On a load, the transition edge captures mem_rdata:
    - data owner: d_rdata = mem_rdata.
    - fetch owner: f_rdata = latched addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - Stores leave d_rdata unchanged.
  - Requester inputs are ignored during ACCESS.
- DONE:
  - mem_en = 0, mem_write = 0.
  - The owner's ack = 1 for exactly this cycle; the other ack stays 0.
  - Next edge goes to IDLE.
- Timing, with grant edge E:
  - mem_en is high for the MEM_LAT cycles after E.
  - ack is high in the cycle after edge E+MEM_LAT.
  - The earliest next grant is at edge E+MEM_LAT+2, giving throughput of one access per MEM_LAT+2 cycles.
- Requester rule: after seeing ack at edge E+MEM_LAT+1, the requester deasserts req (or presents a new request) in that cycle. A req still high when sampled in IDLE is a new request.
- mem_addr and mem_wdata hold their latched values in IDLE and DONE. This is don't-care to memory because mem_en = 0.
- f_rdata and d_rdata hold their values until overwritten by a later load capture.
- busy = (state != IDLE).
- Reset during ACCESS aborts the access: no ack is issued and last_grant returns to DATA. A partially written store is the memory's responsibility.
- Fetch alignment is not checked. Only addr[2] is used for word select.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0 immediately; after release with no req, state stays IDLE and busy = 0.
- Single fetch, MEM_LAT=2: f_req, f_addr=0x1004, mem_rdata=0xAAAABBBBCCCCDDDD -> mem_en high for 2 cycles with mem_addr=0x1004 and mem_write=0; f_ack is a single pulse 3 cycles after grant; f_rdata=0xAAAABBBB, d_ack stays 0.
- Data store: d_req, d_write=1, d_addr=0x2000, d_wdata=0x0123456789ABCDEF -> mem_write and mem_en high for 2 cycles with those values; d_ack pulses; d_rdata unchanged (0).
- Contention: f_req and d_req held continuously from reset -> grants alternate F,D,F,D (fetch first, since last_grant=DATA); acks spaced 4 cycles apart at MEM_LAT=2.
- Back-to-back data loads at MEM_LAT=1: addr 0x10 then 0x18 with mem_rdata 0x11 then 0x22 -> d_rdata=0x11 then 0x22; grants 3 cycles apart.
- Reset mid-access: assert reset during the second ACCESS cycle of a fetch -> no f_ack, mem_en drops immediately; after release, simultaneous requests grant fetch first.
